// File: rtl/wgt_buf_pkg.sv
// Shared constants and types for the ring-ordered multi-bank weight buffer.
// Bank pointer and occupancy widths are derived from the bank count.
package wgt_buf_pkg;

    localparam int DEF_NUM_BANKS = 4;

    function automatic int bank_idx_width(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    localparam int BANK_IDX_W = bank_idx_width(DEF_NUM_BANKS);
    localparam int COUNT_W    = BANK_IDX_W + 1;

    typedef enum logic [1:0] {
        RD_LAT_ONE = 2'd1,
        RD_LAT_TWO = 2'd2
    } rd_lat_e;

endpackage

// File: rtl/wgt_bank_ctrl.sv
// Bank ownership tracker: write/read ring pointers, occupancy count,
// commit/release arbitration, status outputs and sticky misuse flags.
module wgt_bank_ctrl
    import wgt_buf_pkg::*;
#(
    parameter int NUM_BANKS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic                         wr_commit,
    input  logic                         rd_en,
    input  logic                         rd_release,
    output logic [$clog2(NUM_BANKS)-1:0] wp,
    output logic [$clog2(NUM_BANKS)-1:0] rp,
    output logic [$clog2(NUM_BANKS):0]   full_count,
    output logic                         wr_bank_avail,
    output logic                         rd_bank_ready,
    output logic                         wr_accept,
    output logic                         rd_accept,
    output logic                         err_commit_full,
    output logic                         err_release_empty,
    output logic                         err_access
);

    localparam int BW = bank_idx_width(NUM_BANKS);
    localparam int CW = BW + 1;

    logic commit_ok;
    logic release_ok;

    assign wr_bank_avail = (full_count < CW'(NUM_BANKS));
    assign rd_bank_ready = (full_count != '0);
    assign wr_accept     = wr_en & wr_bank_avail;
    assign rd_accept     = rd_en & rd_bank_ready;
    assign commit_ok     = wr_commit & wr_bank_avail;
    assign release_ok    = rd_release & rd_bank_ready;

    // Pointers wrap naturally because NUM_BANKS is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp         <= '0;
            rp         <= '0;
            full_count <= '0;
        end else begin
            if (commit_ok)  wp <= wp + BW'(1);
            if (release_ok) rp <= rp + BW'(1);
            unique case ({commit_ok, release_ok})
                2'b10:   full_count <= full_count + CW'(1);
                2'b01:   full_count <= full_count - CW'(1);
                default: full_count <= full_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_commit_full   <= 1'b0;
            err_release_empty <= 1'b0;
            err_access        <= 1'b0;
        end else begin
            if (wr_commit && !wr_bank_avail)  err_commit_full   <= 1'b1;
            if (rd_release && !rd_bank_ready) err_release_empty <= 1'b1;
            if ((wr_en && !wr_bank_avail) || (rd_en && !rd_bank_ready))
                err_access <= 1'b1;
        end
    end

endmodule

// File: rtl/wgt_bank_ring.sv
// Ring-ordered multi-bank weight buffer between the weight DMA and the
// systolic array B-vector input, with a 1- or 2-stage read pipeline.
module wgt_bank_ring
    import wgt_buf_pkg::*;
#(
    parameter int TN         = 14,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_BANKS  = 4,
    parameter int RD_LAT     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [TN*8-1:0]              wr_data,
    input  logic                         wr_commit,
    output logic                         wr_bank_avail,
    output logic [$clog2(NUM_BANKS)-1:0] wr_bank_idx,
    input  logic                         rd_en,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic                         rd_release,
    output logic                         rd_bank_ready,
    output logic [$clog2(NUM_BANKS)-1:0] rd_bank_idx,
    output logic                         rd_valid,
    output logic [TN*8-1:0]              rd_data,
    output logic [$clog2(NUM_BANKS):0]   full_count,
    output logic                         err_commit_full,
    output logic                         err_release_empty,
    output logic                         err_access
);

    localparam int DW    = TN * 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam rd_lat_e LAT_MODE = (RD_LAT == 2) ? RD_LAT_TWO : RD_LAT_ONE;

    // Handshakes: a request (wr_en, wr_commit, rd_en, rd_release) takes effect
    // only in a cycle where its ready status (wr_bank_avail or rd_bank_ready)
    // is high at the clock edge; otherwise it is dropped and flagged.
    logic wr_accept;
    logic rd_accept;

    logic [DW-1:0] mem [NUM_BANKS][DEPTH];

    wgt_bank_ctrl #(
        .NUM_BANKS(NUM_BANKS)
    ) u_ctrl (
        .clk              (clk),
        .rst              (rst),
        .wr_en            (wr_en),
        .wr_commit        (wr_commit),
        .rd_en            (rd_en),
        .rd_release       (rd_release),
        .wp               (wr_bank_idx),
        .rp               (rd_bank_idx),
        .full_count       (full_count),
        .wr_bank_avail    (wr_bank_avail),
        .rd_bank_ready    (rd_bank_ready),
        .wr_accept        (wr_accept),
        .rd_accept        (rd_accept),
        .err_commit_full  (err_commit_full),
        .err_release_empty(err_release_empty),
        .err_access       (err_access)
    );

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_bank_idx][wr_addr] <= wr_data;
    end

    logic          s1_valid;
    logic [DW-1:0] s1_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_accept;
            if (rd_accept) s1_data <= mem[rd_bank_idx][rd_addr];
        end
    end

    generate
        if (LAT_MODE == RD_LAT_TWO) begin : g_lat2
            logic          s2_valid;
            logic [DW-1:0] s2_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) s2_data <= s1_data;
                end
            end

            assign rd_valid = s2_valid;
            assign rd_data  = s2_data;
        end else begin : g_lat1
            assign rd_valid = s1_valid;
            assign rd_data  = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_wgt_bank_ring.sv
// Bench for wgt_bank_ring: one RD_LAT=1 and one RD_LAT=2 instance share the
// same stimulus and are both checked against a bank/queue reference model.
module tb_wgt_bank_ring;

    localparam int TN = 14;
    localparam int AW = 7;
    localparam int NB = 4;
    localparam int DW = TN * 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_commit = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_release = 1'b0;

    logic          avail_a, ready_a, valid_a, ecf_a, ere_a, eacc_a;
    logic [1:0]    widx_a, ridx_a;
    logic [2:0]    fc_a;
    logic [DW-1:0] data_a;
    logic          avail_b, ready_b, valid_b, ecf_b, ere_b, eacc_b;
    logic [1:0]    widx_b, ridx_b;
    logic [2:0]    fc_b;
    logic [DW-1:0] data_b;

    wgt_bank_ring #(.TN(TN), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit),
        .wr_bank_avail(avail_a), .wr_bank_idx(widx_a),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
        .rd_bank_ready(ready_a), .rd_bank_idx(ridx_a),
        .rd_valid(valid_a), .rd_data(data_a), .full_count(fc_a),
        .err_commit_full(ecf_a), .err_release_empty(ere_a), .err_access(eacc_a)
    );

    wgt_bank_ring #(.TN(TN), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit),
        .wr_bank_avail(avail_b), .wr_bank_idx(widx_b),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
        .rd_bank_ready(ready_b), .rd_bank_idx(ridx_b),
        .rd_valid(valid_b), .rd_data(data_b), .full_count(fc_b),
        .err_commit_full(ecf_b), .err_release_empty(ere_b), .err_access(eacc_b)
    );

    // Reference model: bank contents, ring pointers, occupancy, flags.
    logic [DW-1:0] mem_m [NB][2**AW];
    int            wp_m, rp_m, cnt_m, cyc;
    bit            e_cf, e_re, e_acc;
    logic [DW-1:0] exp_q1[$];
    logic [DW-1:0] exp_q2[$];
    int            due_q1[$];
    int            due_q2[$];
    logic [DW-1:0] last1, last2;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_inst(input string p, input logic v, input logic [DW-1:0] d,
                              input logic ev, input logic [DW-1:0] ed,
                              input logic av, input logic rdy, input logic [1:0] wi,
                              input logic [1:0] ri, input logic [2:0] fc,
                              input logic ecf, input logic ere, input logic eacc);
        check_eq({p, "rd_valid"}, 128'(v), 128'(ev));
        check_eq({p, "rd_data"}, 128'(d), 128'(ed));
        check_eq({p, "wr_bank_avail"}, 128'(av), 128'(cnt_m < NB));
        check_eq({p, "rd_bank_ready"}, 128'(rdy), 128'(cnt_m != 0));
        check_eq({p, "wr_bank_idx"}, 128'(wi), 128'(wp_m));
        check_eq({p, "rd_bank_idx"}, 128'(ri), 128'(rp_m));
        check_eq({p, "full_count"}, 128'(fc), 128'(cnt_m));
        check_eq({p, "err_commit_full"}, 128'(ecf), 128'(e_cf));
        check_eq({p, "err_release_empty"}, 128'(ere), 128'(e_re));
        check_eq({p, "err_access"}, 128'(eacc), 128'(e_acc));
    endtask

    task automatic check_all();
        logic ev1, ev2;
        ev1 = 1'b0;
        ev2 = 1'b0;
        if (due_q1.size() != 0 && due_q1[0] == cyc) begin
            ev1 = 1'b1;
            last1 = exp_q1.pop_front();
            void'(due_q1.pop_front());
        end
        if (due_q2.size() != 0 && due_q2[0] == cyc) begin
            ev2 = 1'b1;
            last2 = exp_q2.pop_front();
            void'(due_q2.pop_front());
        end
        check_inst("l1.", valid_a, data_a, ev1, last1, avail_a, ready_a, widx_a, ridx_a,
                   fc_a, ecf_a, ere_a, eacc_a);
        check_inst("l2.", valid_b, data_b, ev2, last2, avail_b, ready_b, widx_b, ridx_b,
                   fc_b, ecf_b, ere_b, eacc_b);
    endtask

    // One clock of stimulus: drive, update the model from the rules, check.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic wc, input logic re, input logic [AW-1:0] ra,
                        input logic rr);
        bit avail, ready, c_ok, r_ok;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_commit = wc;
        rd_en = re; rd_addr = ra; rd_release = rr;
        avail = (cnt_m < NB);
        ready = (cnt_m != 0);
        if (we) begin
            if (avail) mem_m[wp_m][wa] = wd;
            else e_acc = 1'b1;
        end
        if (re) begin
            if (ready) begin
                exp_q1.push_back(mem_m[rp_m][ra]); due_q1.push_back(cyc + 1);
                exp_q2.push_back(mem_m[rp_m][ra]); due_q2.push_back(cyc + 2);
            end else begin
                e_acc = 1'b1;
            end
        end
        c_ok = wc && avail;
        r_ok = rr && ready;
        if (wc && !avail) e_cf = 1'b1;
        if (rr && !ready) e_re = 1'b1;
        wp_m  = (wp_m + int'(c_ok)) % NB;
        rp_m  = (rp_m + int'(r_ok)) % NB;
        cnt_m = cnt_m + int'(c_ok) - int'(r_ok);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        wr_en = 1'b0; wr_commit = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
        rst = 1'b1;
        #1;
        wp_m = 0; rp_m = 0; cnt_m = 0;
        e_cf = 1'b0; e_re = 1'b0; e_acc = 1'b0;
        exp_q1.delete(); exp_q2.delete(); due_q1.delete(); due_q2.delete();
        last1 = '0; last2 = '0;
        check_all();
        repeat (2) begin
            @(negedge clk);
            check_all();
        end
        rst = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, 16'($urandom)};
    endfunction

    initial begin
        logic [DW-1:0] pat;
        cyc = 0;
        @(negedge clk);
        do_reset();
        idle();

        // Fill bank 0 with a {bank,row}-tagged pattern, commit, read row 5.
        for (int r = 0; r < 2**AW; r++) begin
            pat = {$urandom, $urandom, $urandom, 8'd0, 8'(r)};
            step(1'b1, AW'(r), pat, 1'b0, 1'b0, '0, 1'b0);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, AW'(5), 1'b0);
        idle(); idle();

        // Fill and commit the other three banks, then overflow attempts.
        for (int b = 1; b < NB; b++) begin
            for (int k = 0; k < 4; k++)
                step(1'b1, AW'($urandom_range(0, 2**AW - 1)), rand_data(), 1'b0, 1'b0, '0, 1'b0);
            step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, AW'(5), rand_data(), 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, AW'(5), 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, AW'(6), 1'b0);
        idle(); idle();

        // Drain to two banks, then same-cycle commit+release across the wrap.
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b1, AW'(3), rand_data(), 1'b1, 1'b0, '0, 1'b1);
        step(1'b1, AW'(9), rand_data(), 1'b1, 1'b0, '0, 1'b1);

        // Ten back-to-back reads, release with the last one.
        for (int i = 0; i < 10; i++)
            step(1'b0, '0, '0, 1'b0, 1'b1, AW'($urandom_range(0, 2**AW - 1)), 1'(i == 9));
        repeat (3) idle();

        // Randomized mixed traffic.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 2**AW - 1)), rand_data(),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 2**AW - 1)), 1'($urandom_range(0, 3) == 0));
        repeat (3) idle();

        // Reset with reads in flight and three banks committed.
        for (int i = 0; i < NB && cnt_m < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < NB && cnt_m > 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, AW'(1), 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, AW'(2), 1'b0);
        do_reset();
        idle(); idle();

        // Release and read while empty.
        step(1'b0, '0, '0, 1'b0, 1'b1, AW'(4), 1'b1);
        idle(); idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
